// File: rtl/frame_bank_pkg.sv
// Shared constants for the frame bank arbiter: one-hot FSM encodings and the
// frame bank address map.
package frame_bank_pkg;

   localparam logic [3:0] ST_WAIT    = 4'b0001;
   localparam logic [3:0] ST_CAPTURE = 4'b0010;
   localparam logic [3:0] ST_SKIP    = 4'b0100;
   localparam logic [3:0] ST_COMMIT  = 4'b1000;

   localparam logic [15:0] BANK0_BASE  = 16'h0000;
   localparam logic [15:0] BANK1_BASE  = 16'h8000;
   localparam logic [15:0] FIELD_WORDS = 16'h5460;

endpackage

// File: rtl/frame_bank_arbiter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise and
// fall pulses derived from the synchronized level.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_llc2,
   input  logic resetx,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/frame_bank_arbiter.sv
// Double-buffered odd-field capture with a CPU lock/ack handshake on the ready bank.
// Define FRAME_BANK_WATCHDOG_EN to build the video_lost watchdog and capture abort.
//
// state   | meaning
// WAIT    | idle between fields, waiting for an odd-field start
// CAPTURE | writing the field into wr_bank, wr_gate high
// SKIP    | target bank is locked by the CPU, field discarded
// COMMIT  | one cycle: publish wr_bank as the ready bank, start frame_irq
module frame_bank_arbiter
   import frame_bank_pkg::*;
#(
   parameter int IRQ_LEN     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DROP_W      = 8,
   parameter int TIMEOUT_CYC = 600000
) (
   input  logic              clk_llc2,
   input  logic              resetx,
   input  logic              odd,
   input  logic              vref,
   input  logic              cpu_lock_req,
   output logic              cpu_lock_ack,
   output logic              cpu_bank,
   output logic              wr_bank,
   output logic              wr_gate,
   output logic              ready_valid,
   output logic              frame_irq,
   output logic [7:0]        frame_cnt,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              video_lost
);

   localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYC);

   logic              oddframe;
   logic              odd_level, odd_rise, odd_fall;
   logic              req_level, req_rise, req_fall;
   logic [3:0]        state_q, state_d;
   logic              wr_bank_q, wr_bank_d, wr_gate_q, wr_gate_d;
   logic              ready_bank_q, ready_bank_d, ready_valid_q, ready_valid_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [3:0]        irq_cnt_q, irq_cnt_d;
   logic              ack_q, ack_d, cpu_bank_q, cpu_bank_d;
   logic              grant, release_lock, lock_held, cpu_bank_eff, target, skip, abort;
   logic              unused_ok;

   assign oddframe = odd & vref;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_odd (
      .clk_llc2(clk_llc2), .resetx(resetx), .din(oddframe),
      .level(odd_level), .rise(odd_rise), .fall(odd_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
      .clk_llc2(clk_llc2), .resetx(resetx), .din(cpu_lock_req),
      .level(req_level), .rise(req_rise), .fall(req_fall)
   );

   // Grant is held off during COMMIT so the CPU gets the bank just committed.
   assign grant        = req_level & ~ack_q & ready_valid_q & (state_q != ST_COMMIT);
   assign release_lock = ~req_level & ack_q;
   assign lock_held    = (ack_q & req_level) | grant;
   assign cpu_bank_eff = grant ? ready_bank_q : cpu_bank_q;
   assign target       = ~ready_bank_q;
   assign skip         = lock_held & (target == cpu_bank_eff);

`ifdef FRAME_BANK_WATCHDOG_EN
   logic [19:0] wd_cnt_q, wd_cnt_d;
   logic        video_lost_q, video_lost_d;

   always_comb begin
      wd_cnt_d     = wd_cnt_q;
      video_lost_d = video_lost_q;
      if (odd_rise) begin
         wd_cnt_d     = '0;
         video_lost_d = 1'b0;
      end else begin
         if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 20'd1;
         if (wd_cnt_q >= TIMEOUT_LIM - 20'd1) video_lost_d = 1'b1;
      end
   end

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         wd_cnt_q     <= '0;
         video_lost_q <= 1'b0;
      end else begin
         wd_cnt_q     <= wd_cnt_d;
         video_lost_q <= video_lost_d;
      end
   end

   assign video_lost = video_lost_q;
   assign abort      = video_lost_q & (state_q == ST_CAPTURE);
`else
   assign video_lost = 1'b0;
   assign abort      = 1'b0;
`endif

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         state_q       <= ST_WAIT;
         wr_bank_q     <= 1'b0;
         wr_gate_q     <= 1'b0;
         ready_bank_q  <= 1'b1;
         ready_valid_q <= 1'b0;
         frame_cnt_q   <= '0;
         drop_cnt_q    <= '0;
         irq_cnt_q     <= '0;
         ack_q         <= 1'b0;
         cpu_bank_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_bank_q     <= wr_bank_d;
         wr_gate_q     <= wr_gate_d;
         ready_bank_q  <= ready_bank_d;
         ready_valid_q <= ready_valid_d;
         frame_cnt_q   <= frame_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         irq_cnt_q     <= irq_cnt_d;
         ack_q         <= ack_d;
         cpu_bank_q    <= cpu_bank_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT:    if (odd_rise) state_d = skip ? ST_SKIP : ST_CAPTURE;
         ST_CAPTURE: if (abort) state_d = ST_WAIT; else if (odd_fall) state_d = ST_COMMIT;
         ST_SKIP:    if (odd_fall) state_d = ST_WAIT;
         ST_COMMIT:  state_d = ST_WAIT;
         default:    state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      wr_bank_d     = wr_bank_q;
      wr_gate_d     = wr_gate_q;
      ready_bank_d  = ready_bank_q;
      ready_valid_d = ready_valid_q;
      frame_cnt_d   = frame_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      irq_cnt_d     = irq_cnt_q;
      ack_d         = ack_q;
      cpu_bank_d    = cpu_bank_q;

      if (irq_cnt_q != 4'd0) irq_cnt_d = irq_cnt_q - 4'd1;

      if (grant) begin
         ack_d      = 1'b1;
         cpu_bank_d = ready_bank_q;
      end else if (release_lock) begin
         ack_d = 1'b0;
      end

      case (state_q)
         ST_WAIT: begin
            if (odd_rise) begin
               if (skip) begin
                  if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
               end else begin
                  wr_bank_d = target;
                  wr_gate_d = 1'b1;
               end
            end
         end
         ST_CAPTURE: if (abort || odd_fall) wr_gate_d = 1'b0;
         ST_COMMIT: begin
            ready_bank_d  = wr_bank_q;
            ready_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            irq_cnt_d     = 4'(IRQ_LEN);
         end
         default: ;
      endcase
   end

   // Address map constants feed the write-address generator; lock-request edges are not used here.
   assign unused_ok = ^{BANK0_BASE, BANK1_BASE, FIELD_WORDS, TIMEOUT_LIM, req_rise, req_fall, odd_level};

   assign cpu_lock_ack = ack_q;
   assign cpu_bank     = cpu_bank_q;
   assign wr_bank      = wr_bank_q;
   assign wr_gate      = wr_gate_q;
   assign ready_valid  = ready_valid_q;
   assign frame_irq    = (irq_cnt_q != 4'd0);
   assign frame_cnt    = frame_cnt_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Self-checking bench for frame_bank_arbiter: captured-bank scoreboard plus per-scenario checks.
module tb_frame_bank_arbiter;

   localparam int IRQ_LEN = 4;
   localparam int SYNC    = 2;
   localparam int TMO     = 1000;
   localparam int HI      = 10;
   localparam int LO      = 12;
   localparam int WD_N    = SYNC + 1 + TMO - HI - LO;

   logic       clk_llc2 = 1'b0;
   logic       resetx = 1'b0, odd = 1'b0, vref = 1'b0, cpu_lock_req = 1'b0;
   logic       cpu_lock_ack, cpu_bank, wr_bank, wr_gate, ready_valid, frame_irq, video_lost;
   logic [7:0] frame_cnt, drop_cnt;

   int total = 0, bad = 0;
   int sb_q[$];
   int m_ready = 1, m_frames = 0, m_drops = 0;
   logic gate_prev = 1'b0;
   int irq_run = 0;

   frame_bank_arbiter #(
      .IRQ_LEN(IRQ_LEN), .SYNC_STAGES(SYNC), .DROP_W(8), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_llc2(clk_llc2), .resetx(resetx), .odd(odd), .vref(vref),
      .cpu_lock_req(cpu_lock_req), .cpu_lock_ack(cpu_lock_ack), .cpu_bank(cpu_bank),
      .wr_bank(wr_bank), .wr_gate(wr_gate), .ready_valid(ready_valid),
      .frame_irq(frame_irq), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
      .video_lost(video_lost)
   );

   always #5 clk_llc2 = ~clk_llc2;

   // Scoreboard: each wr_gate rise pops the expected bank; frame_irq pulse width checked on its fall.
   always @(posedge clk_llc2) begin
      #1;
      if (!resetx) begin
         gate_prev = 1'b0;
         irq_run   = 0;
      end else begin
         if (wr_gate && !gate_prev) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL capture_unexpected: wr_gate rose (wr_bank=%0d) but no capture was expected", wr_bank);
            end else begin
               int e;
               e = sb_q.pop_front();
               if (wr_bank !== 1'(e)) begin
                  bad++;
                  $display("FAIL capture_bank: wr_bank=%0d expected=%0d", wr_bank, e);
               end
            end
         end
         if (frame_irq) irq_run++;
         else if (irq_run != 0) begin
            total++;
            if (irq_run != IRQ_LEN) begin
               bad++;
               $display("FAIL irq_width: high %0d cycles expected %0d", irq_run, IRQ_LEN);
            end
            irq_run = 0;
         end
         gate_prev = wr_gate;
      end
   end

   task automatic do_reset();
      resetx = 1'b0; odd = 1'b0; vref = 1'b1; cpu_lock_req = 1'b0;
      sb_q.delete();
      m_ready = 1; m_frames = 0; m_drops = 0;
      repeat (3) @(negedge clk_llc2);
      resetx = 1'b1;
      repeat (2) @(negedge clk_llc2);
   endtask

   // req_at_fs: -1 leaves cpu_lock_req alone, otherwise drives it together with the field start.
   task automatic run_field(input bit exp_skip, input int req_at_fs);
      if (!exp_skip) sb_q.push_back(1 - m_ready);
      @(negedge clk_llc2);
      odd = 1'b1;
      if (req_at_fs >= 0) cpu_lock_req = (req_at_fs != 0);
      repeat (HI) @(negedge clk_llc2);
      odd = 1'b0;
      repeat (LO) @(negedge clk_llc2);
      if (!exp_skip) begin
         m_ready  = 1 - m_ready;
         m_frames = (m_frames + 1) % 256;
      end else if (m_drops < 255) m_drops++;
   endtask

   task automatic check_sb_empty(input string tag);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL %s_captures_missing: %0d expected captures never seen, required 0", tag, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      resetx = 1'b0;
      repeat (2) @(negedge clk_llc2);
      total++;
      if ({cpu_lock_ack, cpu_bank, wr_bank, wr_gate, ready_valid, frame_irq, video_lost} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {cpu_lock_ack, cpu_bank, wr_bank, wr_gate, ready_valid, frame_irq, video_lost});
      end
      total++;
      if ({frame_cnt, drop_cnt} !== 16'h0) begin
         bad++;
         $display("FAIL reset_counts: frame_cnt=%0d drop_cnt=%0d required 0/0", frame_cnt, drop_cnt);
      end
   endtask

   task automatic test_basic();
      do_reset();
      run_field(0, -1);
      total++;
      if (ready_valid !== 1'b1 || frame_cnt !== 8'd1) begin
         bad++;
         $display("FAIL basic_first: ready_valid=%0d frame_cnt=%0d required 1/1", ready_valid, frame_cnt);
      end
      run_field(0, -1);
      run_field(0, -1);
      total++;
      if (frame_cnt !== 8'(m_frames) || drop_cnt !== 8'd0 || frame_cnt !== 8'd3) begin
         bad++;
         $display("FAIL basic_counts: frame_cnt=%0d drop_cnt=%0d required 3/0", frame_cnt, drop_cnt);
      end
      // Odd without vref must not start a field.
      vref = 1'b0;
      odd  = 1'b1;
      repeat (HI) @(negedge clk_llc2);
      odd  = 1'b0;
      repeat (LO) @(negedge clk_llc2);
      vref = 1'b1;
      total++;
      if (frame_cnt !== 8'd3 || cpu_lock_ack !== 1'b0) begin
         bad++;
         $display("FAIL basic_vref_gate: frame_cnt=%0d ack=%0d required 3/0", frame_cnt, cpu_lock_ack);
      end
      check_sb_empty("basic");
   endtask

   task automatic test_lock();
      do_reset();
      run_field(0, -1);
      @(negedge clk_llc2);
      cpu_lock_req = 1'b1;
      repeat (3) @(negedge clk_llc2);
      total++;
      if (cpu_lock_ack !== 1'b1 || cpu_bank !== 1'b0) begin
         bad++;
         $display("FAIL lock_grant: ack=%0d cpu_bank=%0d required 1/0", cpu_lock_ack, cpu_bank);
      end
      run_field(0, -1);
      run_field(1, -1);
      run_field(1, -1);
      total++;
      if (drop_cnt !== 8'(m_drops) || drop_cnt !== 8'd2 || frame_cnt !== 8'd2) begin
         bad++;
         $display("FAIL lock_skips: drop_cnt=%0d frame_cnt=%0d required 2/2", drop_cnt, frame_cnt);
      end
      cpu_lock_req = 1'b0;
      repeat (4) @(negedge clk_llc2);
      total++;
      if (cpu_lock_ack !== 1'b0 || cpu_bank !== 1'b0) begin
         bad++;
         $display("FAIL lock_release: ack=%0d cpu_bank=%0d required 0/0", cpu_lock_ack, cpu_bank);
      end
      run_field(0, -1);
      total++;
      if (wr_bank !== 1'b0 || frame_cnt !== 8'd3) begin
         bad++;
         $display("FAIL lock_after_release: wr_bank=%0d frame_cnt=%0d required 0/3", wr_bank, frame_cnt);
      end
      check_sb_empty("lock");
   endtask

   task automatic test_grant_in_commit();
      do_reset();
      run_field(0, -1);
      sb_q.push_back(1 - m_ready);
      @(negedge clk_llc2);
      odd = 1'b1;
      repeat (HI) @(negedge clk_llc2);
      odd = 1'b0;
      @(negedge clk_llc2);
      cpu_lock_req = 1'b1;
      repeat (3) @(negedge clk_llc2);
      total++;
      if (cpu_lock_ack !== 1'b0) begin
         bad++;
         $display("FAIL commit_defer: ack=%0d during commit cycle, required 0", cpu_lock_ack);
      end
      @(negedge clk_llc2);
      total++;
      if (cpu_lock_ack !== 1'b1 || cpu_bank !== 1'b1) begin
         bad++;
         $display("FAIL commit_grant: ack=%0d cpu_bank=%0d required 1/1", cpu_lock_ack, cpu_bank);
      end
      repeat (LO - 5) @(negedge clk_llc2);
      m_ready  = 1 - m_ready;
      m_frames = m_frames + 1;
      check_sb_empty("commit");
   endtask

   // Continues from test_grant_in_commit: locked on bank 1, ready bank 1.
   task automatic test_release_at_fs();
      run_field(0, -1);
      run_field(0, 0);
      total++;
      if (drop_cnt !== 8'd0 || frame_cnt !== 8'd4 || cpu_lock_ack !== 1'b0) begin
         bad++;
         $display("FAIL release_at_fs: drop_cnt=%0d frame_cnt=%0d ack=%0d required 0/4/0",
                  drop_cnt, frame_cnt, cpu_lock_ack);
      end
      check_sb_empty("release_fs");
   endtask

   task automatic test_reset_mid_capture();
      do_reset();
      run_field(0, -1);
      sb_q.push_back(1 - m_ready);
      @(negedge clk_llc2);
      odd = 1'b1;
      repeat (6) @(negedge clk_llc2);
      total++;
      if (wr_gate !== 1'b1) begin
         bad++;
         $display("FAIL midcap_gate_on: wr_gate=%0d required 1", wr_gate);
      end
      #3 resetx = 1'b0;
      #1;
      total++;
      if ({wr_gate, ready_valid, frame_irq} !== 3'b000) begin
         bad++;
         $display("FAIL midcap_async: gate/valid/irq=%b required 000", {wr_gate, ready_valid, frame_irq});
      end
      odd = 1'b0;
      repeat (3) @(negedge clk_llc2);
      resetx = 1'b1;
      m_ready = 1; m_frames = 0; m_drops = 0;
      repeat (3) @(negedge clk_llc2);
      run_field(0, -1);
      total++;
      if (frame_cnt !== 8'd1 || wr_bank !== 1'b0) begin
         bad++;
         $display("FAIL midcap_restart: frame_cnt=%0d wr_bank=%0d required 1/0", frame_cnt, wr_bank);
      end
      check_sb_empty("midcap");
   endtask

   task automatic test_saturation_wrap();
      do_reset();
      run_field(0, -1);
      cpu_lock_req = 1'b1;
      repeat (4) @(negedge clk_llc2);
      run_field(0, -1);
      for (int i = 0; i < 258; i++) run_field(1, -1);
      total++;
      if (drop_cnt !== 8'(m_drops) || drop_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL drop_saturate: drop_cnt=%0d required 255", drop_cnt);
      end
      cpu_lock_req = 1'b0;
      repeat (4) @(negedge clk_llc2);
      for (int i = 0; i < 253; i++) run_field(0, -1);
      total++;
      if (frame_cnt !== 8'd255) begin
         bad++;
         $display("FAIL frame_cnt_max: frame_cnt=%0d required 255", frame_cnt);
      end
      run_field(0, -1);
      total++;
      if (frame_cnt !== 8'(m_frames) || frame_cnt !== 8'd0 || drop_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL frame_cnt_wrap: frame_cnt=%0d drop_cnt=%0d required 0/255", frame_cnt, drop_cnt);
      end
      check_sb_empty("satwrap");
   endtask

   task automatic test_watchdog();
`ifdef FRAME_BANK_WATCHDOG_EN
      int n;
      do_reset();
      run_field(0, -1);
      n = 0;
      while (video_lost !== 1'b1 && n < 2 * TMO) begin
         @(negedge clk_llc2);
         n++;
      end
      total++;
      if (n != WD_N) begin
         bad++;
         $display("FAIL watchdog_timeout: video_lost after %0d cycles past field end, required %0d", n, WD_N);
      end
      run_field(0, -1);
      total++;
      if (video_lost !== 1'b0 || frame_cnt !== 8'd2) begin
         bad++;
         $display("FAIL watchdog_clear: video_lost=%0d frame_cnt=%0d required 0/2", video_lost, frame_cnt);
      end
      check_sb_empty("watchdog");
`else
      repeat (TMO + 100) @(negedge clk_llc2);
      total++;
      if (video_lost !== 1'b0) begin
         bad++;
         $display("FAIL watchdog_tied: video_lost=%0d required 0", video_lost);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lock();
      test_grant_in_commit();
      test_release_at_fs();
      test_reset_mid_capture();
      test_saturation_wrap();
      test_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_bank_arbiter.md
Name: frame_bank_arbiter

Overview:
- Sequences capture of 180x120 RGB565 odd fields into the two on-chip frame banks (bank 0 at word 0x0000, bank 1 at word 0x8000).
- Arbitrates bank ownership between the video writer and the Eagle CPU through a lock/acknowledge handshake, so the CPU always reads a complete, stable frame.
- Sits in the clk_llc2 domain between the video-decode/write-address logic and the Eagle interrupt/interface logic. Drives the bank select bit and the capture gate, and raises a frame-ready interrupt.

Parameters:
- IRQ_LEN, 4, frame_irq pulse width in clk_llc2 cycles (1..15)
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
- DROP_W, 8, width of the saturating dropped-field counter
- TIMEOUT_CYC, 600000, clk_llc2 cycles without a field start before video_lost asserts (fits 20 bits)

Ports:
- clk_llc2  in  1  13.5 MHz video pixel clock
- resetx  in  1  asynchronous active-low reset
- odd  in  1  decoder odd-field flag (asynchronous to this block)
- vref  in  1  decoder vertical reference (asynchronous)
- cpu_lock_req  in  1  CPU level request to own the ready bank (asynchronous, from clk_lsdr register)
- cpu_lock_ack  out  1  lock granted; cpu_bank is valid and frozen
- cpu_bank  out  1  bank the CPU may read
- wr_bank  out  1  bank currently written; drives write-address bit 15
- wr_gate  out  1  capture enable for the write-address and data path
- ready_valid  out  1  at least one complete field is stored
- frame_irq  out  1  frame-ready pulse
- frame_cnt  out  8  committed field count, wraps
- drop_cnt  out  DROP_W  skipped fields, saturating
- video_lost  out  1  no field start seen within TIMEOUT_CYC

Behaviour:
- Reset is asynchronous, active-low, clock clk_llc2.
- Reset values: every output 0. Internal ready_bank = 1, so the first capture targets bank 0. FSM in WAIT.
- Synchronizers: oddframe = odd & vref, synchronized over SYNC_STAGES flops. cpu_lock_req is synchronized the same way.
- Edge detection: fs = rising edge of synchronized oddframe; fe = falling edge.
- FSM is one-hot with states WAIT, CAPTURE, SKIP, COMMIT.
  - WAIT: on fs, target = ~ready_bank.
    - If lock is held (including a grant in this same cycle) and target == cpu_bank: go to SKIP, increment drop_cnt.
    - Otherwise: go to CAPTURE, wr_bank <= target, wr_gate <= 1.
  - CAPTURE: on fe, wr_gate <= 0 and go to COMMIT.
  - SKIP: on fe, return to WAIT. wr_gate stays 0.
  - COMMIT (1 cycle): ready_bank <= wr_bank, ready_valid <= 1, frame_cnt++, start frame_irq; then go to WAIT.
- Latency: oddframe rise to wr_gate high is SYNC_STAGES+1 cycles (3 at default). The fall path has the same latency.
- fs seen outside WAIT is ignored. This only happens on a decoder glitch; fe always closes the field.
- Lock grant:
  - When synchronized req = 1, ack = 0, ready_valid = 1 and the state is not COMMIT: next cycle ack <= 1 and cpu_bank <= ready_bank.
  - If req is high before ready_valid, the grant waits until the first commit.
  - If req rises during COMMIT, the grant is deferred one cycle and takes the newly committed bank.
- Release: when synchronized req = 0 and ack = 1, ack <= 0 next cycle. cpu_bank holds its last value.
- Release and fs in the same cycle: the release wins, so the field is captured, not skipped.
- While locked, the writer fills the other bank once and then skips until release. The CPU bank is never written.
- frame_irq: high for exactly IRQ_LEN cycles starting the cycle after COMMIT. A new COMMIT restarts the count.
- drop_cnt: saturates at all-ones. frame_cnt: wraps 255 -> 0.
- Reset mid-capture: wr_gate drops immediately. The partial field is discarded and ready_valid = 0.

Optional Feature:
- Macro FRAME_BANK_WATCHDOG_EN.
- Defined:
  - A 20-bit counter clears on fs and otherwise increments, saturating.
  - video_lost <= 1 when the count reaches TIMEOUT_CYC; it clears on the next fs.
  - While video_lost = 1, a CAPTURE state is forced to WAIT with wr_gate = 0 and no commit.
- Undefined: no counter is built, video_lost is tied 0, and no forced abort occurs.

Decomposition:
- Shared package frame_bank_pkg holds:
  - one-hot state constants (WAIT = 4'b0001, CAPTURE = 4'b0010, SKIP = 4'b0100, COMMIT = 4'b1000)
  - BANK0_BASE = 16'h0000 and BANK1_BASE = 16'h8000
  - FIELD_WORDS = 16'h5460
- One sub-module, sync_edge: parameterised SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated twice, for oddframe and cpu_lock_req.

Test Plan:
- Reset, then three odd fields with no lock -> wr_bank sequence 0,1,0. frame_cnt = 3, ready_valid = 1 after the first fe, frame_irq high 4 cycles after each commit, drop_cnt = 0.
- After field 1 (ready = 0), hold cpu_lock_req -> ack and cpu_bank = 0 within 3 cycles. Field 2 writes bank 1; fields 3 and 4 skip (drop_cnt = 2, wr_gate stays 0). Release -> field 5 captured into bank 0.
- Assert cpu_lock_req in the same cycle COMMIT of bank 1 occurs -> ack one cycle later with cpu_bank = 1.
- Deassert req in the cycle fs arrives while the target equals cpu_bank -> field captured, drop_cnt unchanged.
- Pull resetx low mid-CAPTURE -> wr_gate, ready_valid and frame_irq go to 0 asynchronously. Next field targets bank 0.
- With FRAME_BANK_WATCHDOG_EN defined and TIMEOUT_CYC = 1000, stop odd -> video_lost = 1 at cycle 1000 after the last fs. Restore odd -> video_lost clears at the next fs.
